// File: rtl/bin2bcd_serial_pkg.sv
// Shared definitions for the binary-to-BCD front end of the seven-segment display.
// Holds the FSM state encoding, the blank nibble code and the default sizing.
package bin2bcd_serial_pkg;

  localparam int DEF_BIN_W  = 14;
  localparam int DEF_DIGITS = 4;

  // The display decoder renders this code as an unlit digit
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Largest operand that fits in the given number of decimal digits
  function automatic int unsigned max_bcd_value(input int digits);
    int unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_serial_bcd_add3.sv
// bcd_add3: one double-dabble correction cell, adds 3 to a BCD nibble that is 5 or more.
// Latency: combinational. Backpressure: none.
// Instantiated once per scratch digit so the shift never leaves a nibble above 9.
module bcd_add3
  import bin2bcd_serial_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin2bcd_serial.sv
// bin2bcd_serial: serial double-dabble converter; define BIN2BCD_BLANK_EN to blank leading zero digits.
// Latency: start taken at edge N gives done/value in cycle N+BIN_W+1; one conversion per BIN_W+2 cycles.
// Backpressure: none; start is sampled only in IDLE, requests while busy or done are dropped.
module bin2bcd_serial
  import bin2bcd_serial_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [BIN_W-1:0]    bin,
  input  logic [DIGITS-1:0]   dp,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [4*DIGITS-1:0] value,
  output logic [DIGITS-1:0]   dots
);

  // One headroom digit above the displayed ones so in-range carries are never lost
  localparam int          SCR_D   = DIGITS + 1;
  localparam int          SCR_W   = 4 * SCR_D;
  localparam int          CNT_W   = $clog2(BIN_W + 1);
  localparam int unsigned MAX_VAL = max_bcd_value(DIGITS);

  state_t              state, state_nxt;
  logic [SCR_W-1:0]    scratch, scratch_adj, scratch_nxt;
  logic [BIN_W-1:0]    shreg;
  logic [CNT_W-1:0]    cnt;
  logic [DIGITS-1:0]   dp_q;
  logic                ovf_pend, ovf_final;
  logic                accept, last_iter;
  logic [4*DIGITS-1:0] result_bcd, result_disp;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (cnt == CNT_W'(BIN_W - 1)) begin
          last_iter = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  for (genvar g = 0; g < SCR_D; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (scratch[4*g +: 4]),
      .dout (scratch_adj[4*g +: 4])
    );
  end

  assign scratch_nxt = {scratch_adj[SCR_W-2:0], shreg[BIN_W-1]};
  assign result_bcd  = scratch_nxt[4*DIGITS-1:0];
  // A carry off the headroom digit can only come from an out-of-range operand
  assign ovf_final   = ovf_pend | scratch_adj[SCR_W-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scratch  <= '0;
      shreg    <= '0;
      cnt      <= '0;
      dp_q     <= '0;
      ovf_pend <= 1'b0;
    end else if (accept) begin
      scratch  <= '0;
      shreg    <= bin;
      cnt      <= '0;
      dp_q     <= dp;
      ovf_pend <= (32'(bin) > MAX_VAL);
    end else if (state == ST_SHIFT) begin
      scratch  <= scratch_nxt;
      shreg    <= shreg << 1;
      cnt      <= cnt + CNT_W'(1);
      ovf_pend <= ovf_final;
    end
  end

`ifdef BIN2BCD_BLANK_EN
  logic blanking;

  // Walk down from the top digit; the first nonzero digit or set dot ends blanking
  always_comb begin
    blanking    = 1'b1;
    result_disp = result_bcd;
    for (int i = DIGITS - 1; i > 0; i--) begin
      if (dp_q[i] || (result_bcd[4*i +: 4] != 4'd0)) blanking = 1'b0;
      if (blanking) result_disp[4*i +: 4] = BLANK_NIBBLE;
    end
  end
`else
  assign result_disp = result_bcd;
`endif

  // Outputs load on the edge entering DONE so they are valid alongside the done pulse
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value    <= '0;
      dots     <= '0;
      overflow <= 1'b0;
    end else if (last_iter) begin
      overflow <= ovf_final;
      value    <= ovf_final ? {DIGITS{4'h9}} : result_disp;
      dots     <= ovf_final ? {DIGITS{1'b1}} : dp_q;
    end
  end

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Directed bench for bin2bcd_serial: timing, conversion results, overflow, blanking, reset abort, back-to-back.
module tb_bin2bcd_serial;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [13:0] bin   = '0;
  logic [3:0]  dp    = '0;
  logic        busy, done, overflow;
  logic [15:0] value;
  logic [3:0]  dots;

  int checks = 0;
  int passes = 0;

`ifdef BIN2BCD_BLANK_EN
  localparam logic [15:0] EXP_7    = 16'hFFF7;
  localparam logic [15:0] EXP_7_DP = 16'hF007;
  localparam logic [15:0] EXP_50   = 16'hFF50;
  localparam logic [15:0] EXP_305  = 16'hF305;
`else
  localparam logic [15:0] EXP_7    = 16'h0007;
  localparam logic [15:0] EXP_7_DP = 16'h0007;
  localparam logic [15:0] EXP_50   = 16'h0050;
  localparam logic [15:0] EXP_305  = 16'h0305;
`endif

  always #5 clock = ~clock;

  bin2bcd_serial dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .bin      (bin),
    .dp       (dp),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .value    (value),
    .dots     (dots)
  );

  // Drive a one-edge start pulse; returns just after the accepting edge
  task automatic start_conv(input logic [13:0] b, input logic [3:0] d);
    @(negedge clock);
    start = 1'b1;
    bin   = b;
    dp    = d;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  // Cycle index (1 = first cycle after the accepting edge) of done, -1 on timeout
  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clock);
      if (done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic do_conv(input logic [13:0] b, input logic [3:0] d, output int cyc);
    start_conv(b, d);
    wait_done(cyc);
  endtask

  task automatic test_reset;
    #12;
    checks++; if ({busy, done, overflow} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {busy, done, overflow}); else passes++;
    checks++; if (value !== 16'h0000) $display("FAIL reset_value: got %h want 0000", value); else passes++;
    checks++; if (dots !== 4'b0000) $display("FAIL reset_dots: got %b want 0000", dots); else passes++;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if ({busy, done} !== 2'b00) $display("FAIL reset_release_idle: got %b want 00", {busy, done}); else passes++;
  endtask

  task automatic test_basic;
    start_conv(14'd1234, 4'b0100);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clock);
      checks++; if (busy !== (k <= 15)) $display("FAIL basic_busy c%0d: got %b want %b", k, busy, (k <= 15)); else passes++;
      checks++; if (done !== (k == 15)) $display("FAIL basic_done c%0d: got %b want %b", k, done, (k == 15)); else passes++;
      if (k == 14) begin
        checks++; if (value !== 16'h0000) $display("FAIL basic_value_early: got %h want 0000", value); else passes++;
      end
      if (k == 15) begin
        checks++; if (value !== 16'h1234) $display("FAIL basic_value: got %h want 1234", value); else passes++;
        checks++; if (dots !== 4'b0100) $display("FAIL basic_dots: got %b want 0100", dots); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL basic_ovf: got %b want 0", overflow); else passes++;
      end
    end
  endtask

  task automatic test_ignore_start;
    int done_at;
    int extra;
    done_at = -1;
    extra   = 0;
    start_conv(14'd1234, 4'b0001);
    for (int k = 1; k <= 22; k++) begin
      @(negedge clock);
      if (done && done_at < 0) begin
        done_at = k;
        checks++; if (value !== 16'h1234) $display("FAIL ignore_value: got %h want 1234", value); else passes++;
      end else if (done) begin
        extra++;
      end
      if (k == 5) begin
        start = 1'b1;
        bin   = 14'd42;
      end
      if (k == 6) start = 1'b0;
    end
    checks++; if (done_at !== 15) $display("FAIL ignore_done_cycle: got %0d want 15", done_at); else passes++;
    checks++; if (extra !== 0) $display("FAIL ignore_queued: got %0d extra done want 0", extra); else passes++;
  endtask

  task automatic test_overflow;
    int cyc;
    do_conv(14'd9999, 4'b0000, cyc);
    checks++; if (cyc !== 15) $display("FAIL max_done_cycle: got %0d want 15", cyc); else passes++;
    checks++; if (value !== 16'h9999) $display("FAIL max_value: got %h want 9999", value); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL max_ovf: got %b want 0", overflow); else passes++;
    do_conv(14'd10000, 4'b0010, cyc);
    checks++; if (cyc !== 15) $display("FAIL ovf_done_cycle: got %0d want 15", cyc); else passes++;
    checks++; if (value !== 16'h9999) $display("FAIL ovf_value: got %h want 9999", value); else passes++;
    checks++; if (dots !== 4'b1111) $display("FAIL ovf_dots: got %b want 1111", dots); else passes++;
    checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", overflow); else passes++;
    repeat (4) @(negedge clock);
    checks++; if ({overflow, value, dots} !== {1'b1, 16'h9999, 4'b1111}) $display("FAIL ovf_held: got %b %h %b want 1 9999 1111", overflow, value, dots); else passes++;
  endtask

  task automatic test_reset_mid;
    int cyc;
    int seen;
    seen = 0;
    start_conv(14'd1234, 4'b0100);
    repeat (8) @(negedge clock);
    reset = 1'b0;
    #1;
    checks++; if ({busy, done, overflow} !== 3'b000) $display("FAIL midrst_flags: got %b want 000", {busy, done, overflow}); else passes++;
    checks++; if (value !== 16'h0000) $display("FAIL midrst_value: got %h want 0000", value); else passes++;
    checks++; if (dots !== 4'b0000) $display("FAIL midrst_dots: got %b want 0000", dots); else passes++;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clock);
      if (done || busy) seen++;
    end
    checks++; if (seen !== 0) $display("FAIL midrst_no_done: got %0d active cycles want 0", seen); else passes++;
    do_conv(14'd50, 4'b0000, cyc);
    checks++; if (cyc !== 15) $display("FAIL post_rst_cycle: got %0d want 15", cyc); else passes++;
    checks++; if (value !== EXP_50) $display("FAIL post_rst_value: got %h want %h", value, EXP_50); else passes++;
  endtask

  task automatic test_blank;
    int cyc;
    do_conv(14'd7, 4'b0000, cyc);
    checks++; if (cyc !== 15) $display("FAIL blank_cycle: got %0d want 15", cyc); else passes++;
    checks++; if (value !== EXP_7) $display("FAIL blank_value: got %h want %h", value, EXP_7); else passes++;
    checks++; if (overflow !== 1'b0) $display("FAIL blank_ovf: got %b want 0", overflow); else passes++;
    do_conv(14'd7, 4'b0100, cyc);
    checks++; if (value !== EXP_7_DP) $display("FAIL blank_dp_value: got %h want %h", value, EXP_7_DP); else passes++;
    checks++; if (dots !== 4'b0100) $display("FAIL blank_dp_dots: got %b want 0100", dots); else passes++;
  endtask

  task automatic test_back_to_back;
    int d_at[$];
    int double_pulse;
    logic prev_done;
    double_pulse = 0;
    prev_done    = 1'b0;
    @(negedge clock);
    start = 1'b1;
    bin   = 14'd305;
    dp    = 4'b0001;
    @(posedge clock);
    for (int k = 1; k <= 50; k++) begin
      @(negedge clock);
      if (done) begin
        d_at.push_back(k);
        if (prev_done) double_pulse++;
        checks++; if (value !== EXP_305) $display("FAIL b2b_value c%0d: got %h want %h", k, value, EXP_305); else passes++;
      end
      prev_done = done;
    end
    start = 1'b0;
    checks++; if (d_at.size() !== 3) $display("FAIL b2b_count: got %0d want 3", d_at.size()); else passes++;
    checks++; if (double_pulse !== 0) $display("FAIL b2b_single_pulse: got %0d repeats want 0", double_pulse); else passes++;
    if (d_at.size() == 3) begin
      checks++; if (d_at[0] !== 15) $display("FAIL b2b_first: got %0d want 15", d_at[0]); else passes++;
      checks++; if (d_at[1] - d_at[0] !== 16) $display("FAIL b2b_gap1: got %0d want 16", d_at[1] - d_at[0]); else passes++;
      checks++; if (d_at[2] - d_at[1] !== 16) $display("FAIL b2b_gap2: got %0d want 16", d_at[2] - d_at[1]); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignore_start();
    test_overflow();
    test_reset_mid();
    test_blank();
    test_back_to_back();
    repeat (3) @(negedge clock);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/bin2bcd_serial.md
# bin2bcd_serial

Sequential binary-to-BCD converter that sits directly upstream of the seven-segment display top. It accepts a binary count plus decimal-point mask on a start pulse, runs a shift-and-add-3 (double-dabble) loop one bit per clock, and presents a held packed-BCD `value` and `dots` pair to the display's 16-bit value and 4-bit dots inputs. Results are handed off with a single-cycle `done` pulse.

## Interface
- `BIN_W`, 14: binary input width; also the number of iterations.
- `DIGITS`, 4: BCD digits produced. Only 14/4 is verified; `value` width is `4*DIGITS`.
- `clock`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request conversion; sampled only in IDLE.
- `bin`  in  BIN_W  unsigned binary operand; captured with `start`.
- `dp`  in  DIGITS  decimal-point mask; captured with `start`.
- `busy`  out  1  high from the cycle after accepted `start` until `done`.
- `done`  out  1  one-cycle pulse; `value`/`dots` are valid and updated in this cycle.
- `overflow`  out  1  held flag: last operand exceeded 10^DIGITS−1.
- `value`  out  4*DIGITS  packed BCD; digit 0 is in [3:0]; held between conversions.
- `dots`  out  DIGITS  captured `dp` of the last conversion; held.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: if `start`=1, capture `bin` into the shift register, `dp` into the dot latch, clear the BCD scratch register and iteration counter, and go to SHIFT. Otherwise stay.
- SHIFT: each cycle, nibbles of the scratch register that are ≥5 get +3, then {scratch, shift} shifts left 1. After BIN_W iterations (counter BIN_W−1 → terminal), go to DONE.
- DONE: load `value`, `dots`, `overflow`; pulse `done`; return to IDLE.
- Overflow: the operand is compared to 10^DIGITS−1 at capture. If greater, the loaded `value` is all nines (0x9999 at DIGITS=4), `dots` is all ones, and `overflow`=1. Otherwise `overflow`=0.
- BCD scratch is DIGITS nibbles plus enough headroom that no carry is lost for BIN_W=14. Carries above the top digit are discarded, because the overflow path covers them.
- `start` while `busy` or in DONE is ignored, not queued.
- `value`, `dots`, `overflow` change only in the DONE cycle.

## Timing
- Reset (async assert, sync release): state IDLE; `busy`=0, `done`=0, `overflow`=0, `value`=0, `dots`=0; scratch and counter cleared.
- Reset mid-conversion aborts the conversion. Outputs return to reset values, and no `done` is produced.
- `start` accepted at edge N. `busy`=1 for cycles N+1 … N+BIN_W+1. `done`=1 and new `value` appear at cycle N+BIN_W+1 (cycle 15 for BIN_W=14). `busy` drops in the next cycle.
- Back-to-back conversions: the earliest next `start` is accepted in the first IDLE cycle after `done`, giving a throughput of BIN_W+2 cycles.
- `done` and `busy` are both high in the DONE cycle.

## Configuration
- `BIN2BCD_BLANK_EN` defined: leading zero digits are replaced by nibble 0xF, which the display decoder renders blank. Digit 0 is never blanked. A dot bit set on a digit stops blanking at that digit and all lower digits. Overflow output is unaffected.
- Not defined: `value` is the plain BCD result, including leading zeros.

## Structure
- Shared display package holds:
  - the state enum (IDLE, SHIFT, DONE);
  - `BLANK_NIBBLE` = 4'hF;
  - the `DIGITS` and `BIN_W` defaults;
  - a function giving 10^DIGITS−1.
- Sub-module `bcd_add3`: combinational, 4-bit in/out, applies +3 when the input is ≥5. It is instantiated once per digit in the SHIFT datapath.

## Test plan
- Reset, then `bin`=1234, `dp`=0100 with a `start` pulse → `busy` high for cycles 1–15; `done` at cycle 15; `value`=0x1234, `dots`=0100, `overflow`=0.
- `bin`=9999 → `value`=0x9999, `overflow`=0. Then `bin`=10000 → `value`=0x9999, `dots`=1111, `overflow`=1.
- `bin`=7, `dp`=0 → `value`=0x0007 without the macro, and 0xFFF7 with `BIN2BCD_BLANK_EN`. With `dp`=0100 and the macro, `value`=0xF007.
- Pulse `start` again at cycle 5 with `bin`=42 during a 1234 conversion → ignored; `done` still at cycle 15 with 0x1234.
- Assert `reset` at cycle 8 of a conversion → all outputs 0 immediately, no `done`. After release, `bin`=50 converts to 0x0050.
- Back-to-back: `start` held high continuously → conversions complete every 16 cycles, each `done` a single cycle.
